// File: rtl/acounter_updown_param.sv
// Parametrised up/down modulo counter with prescaler, clamped load, wrap/saturate
// boundary handling, registered terminal-count pulse and sticky overflow flag.
module acounter_updown_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] cq,
    output logic             tc,
    output logic             ovf,
    output logic             tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] CMAX = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PMAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);

    generate
        if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
            $error("acounter_updown_param: MODULUS must lie in 2..2**WIDTH");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("acounter_updown_param: PRESCALE must be at least 1");
        end
    endgenerate

    logic [PW-1:0]    pcnt;
    logic             at_bound;
    logic             bnd;
    logic [WIDTH-1:0] ld_clamped;
    logic [WIDTH-1:0] cq_step;

    assign tick       = en & ~load & (pcnt == PMAX);
    assign at_bound   = dir ? (cq == CMAX) : (cq == '0);
    assign bnd        = tick & at_bound;
    assign ld_clamped = ({1'b0, ld_val} < MODW) ? ld_val : CMAX;

    // Boundary value depends on mode; stepping never leaves 0..MODULUS-1.
    always_comb begin
        cq_step = cq;
        if (at_bound) begin
            if (SATURATE != 0) cq_step = cq;
            else               cq_step = dir ? '0 : CMAX;
        end else begin
            cq_step = dir ? (cq + WIDTH'(1)) : (cq - WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cq   <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
            pcnt <= '0;
        end else begin
            ovf <= (ovf & ~clr_ovf) | bnd;
            if (load) begin
                cq   <= ld_clamped;
                pcnt <= '0;
                tc   <= 1'b0;
            end else begin
                tc <= bnd;
                if (en) begin
                    pcnt <= (pcnt == PMAX) ? '0 : (pcnt + PW'(1));
                end
                if (tick) begin
                    cq <= cq_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_acounter_updown_param.sv
// Directed bench for acounter_updown_param: four instances share stimulus,
// each phase checks the instance configured for that feature.
module tb_acounter_updown_param;

    logic       clk = 1'b0;
    logic       reset, en, dir, load, clr_ovf;
    logic [3:0] ld_val;

    logic [3:0] cq_a, cq_s, cq_p, cq_f;
    logic       tc_a, tc_s, tc_p, tc_f;
    logic       ovf_a, ovf_s, ovf_p, ovf_f;
    logic       tick_a, tick_s, tick_p, tick_f;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acounter_updown_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .PRESCALE(1)) u_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .ld_val(ld_val),
        .clr_ovf(clr_ovf), .cq(cq_a), .tc(tc_a), .ovf(ovf_a), .tick(tick_a));

    acounter_updown_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .PRESCALE(1)) u_s (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .ld_val(ld_val),
        .clr_ovf(clr_ovf), .cq(cq_s), .tc(tc_s), .ovf(ovf_s), .tick(tick_s));

    acounter_updown_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(3)) u_p (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .ld_val(ld_val),
        .clr_ovf(clr_ovf), .cq(cq_p), .tc(tc_p), .ovf(ovf_p), .tick(tick_p));

    acounter_updown_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .PRESCALE(1)) u_f (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .ld_val(ld_val),
        .clr_ovf(clr_ovf), .cq(cq_f), .tc(tc_f), .ovf(ovf_f), .tick(tick_f));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; clr_ovf = 1'b0; ld_val = 4'd0;
        #3;
        chk("por_cq", {28'd0, cq_a}, 32'd0);
        chk("por_tc", {31'd0, tc_a}, 32'd0);
        chk("por_ovf", {31'd0, ovf_a}, 32'd0);
        #9;
        reset = 1'b1;
        en = 1'b1; dir = 1'b1;

        // up wrap, modulus 10
        for (int i = 1; i <= 12; i++) begin
            cyc();
            chk("upwrap_cq", {28'd0, cq_a}, i % 10);
            chk("upwrap_tc", {31'd0, tc_a}, (i == 10) ? 32'd1 : 32'd0);
            chk("upwrap_ovf", {31'd0, ovf_a}, (i >= 10) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 5; i++) cyc();
        chk("pre_rst_cq", {28'd0, cq_a}, 32'd7);
        chk("pre_rst_ovf", {31'd0, ovf_a}, 32'd1);

        // asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        chk("arst_cq", {28'd0, cq_a}, 32'd0);
        chk("arst_tc", {31'd0, tc_a}, 32'd0);
        chk("arst_ovf", {31'd0, ovf_a}, 32'd0);
        chk("arst_cq_p", {28'd0, cq_p}, 32'd0);
        en = 1'b0;
        #1;
        reset = 1'b1;
        cyc();

        // load clamp, load beats enable
        load = 1'b1; ld_val = 4'd13; en = 1'b1;
        #1;
        chk("load_tick_a", {31'd0, tick_a}, 32'd0);
        cyc();
        chk("clamp_cq", {28'd0, cq_a}, 32'd9);
        chk("clamp_tc", {31'd0, tc_a}, 32'd0);
        ld_val = 4'd0;
        cyc();
        chk("load0_cq", {28'd0, cq_a}, 32'd0);
        load = 1'b0; dir = 1'b0; en = 1'b1;
        #1;
        chk("down_tick_a", {31'd0, tick_a}, 32'd1);
        cyc();
        chk("dnwrap_cq", {28'd0, cq_a}, 32'd9);
        chk("dnwrap_tc", {31'd0, tc_a}, 32'd1);
        chk("dnwrap_ovf", {31'd0, ovf_a}, 32'd1);
        cyc();
        chk("dn_cq", {28'd0, cq_a}, 32'd8);
        chk("dn_tc", {31'd0, tc_a}, 32'd0);
        load = 1'b1; ld_val = 4'd3;
        cyc();
        chk("ld_win_cq", {28'd0, cq_a}, 32'd3);
        chk("ld_win_tc", {31'd0, tc_a}, 32'd0);

        // saturate mode
        load = 1'b0; en = 1'b0; clr_ovf = 1'b1;
        cyc();
        chk("sat_clr0", {31'd0, ovf_s}, 32'd0);
        clr_ovf = 1'b0; load = 1'b1; ld_val = 4'd8;
        cyc();
        chk("sat_ld8", {28'd0, cq_s}, 32'd8);
        load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk("sat_cq", {28'd0, cq_s}, 32'd9);
            chk("sat_tc", {31'd0, tc_s}, (i >= 2) ? 32'd1 : 32'd0);
            chk("sat_ovf", {31'd0, ovf_s}, (i >= 2) ? 32'd1 : 32'd0);
        end
        clr_ovf = 1'b1;
        cyc();
        chk("sat_setwins", {31'd0, ovf_s}, 32'd1);
        chk("sat_setwins_tc", {31'd0, tc_s}, 32'd1);
        en = 1'b0;
        cyc();
        chk("sat_clr", {31'd0, ovf_s}, 32'd0);
        chk("sat_tc_off", {31'd0, tc_s}, 32'd0);
        clr_ovf = 1'b0;

        // prescale by 3
        load = 1'b1; ld_val = 4'd0;
        cyc();
        load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            #1;
            chk("pre_tick", {31'd0, tick_p}, (k % 3 == 0) ? 32'd1 : 32'd0);
            cyc();
            chk("pre_cq", {28'd0, cq_p}, k / 3);
        end
        cyc();
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("pre_frz_tick", {31'd0, tick_p}, 32'd0);
            cyc();
            chk("pre_frz_cq", {28'd0, cq_p}, 32'd3);
        end
        en = 1'b1;
        cyc();
        chk("pre_resume1", {28'd0, cq_p}, 32'd3);
        #1;
        chk("pre_resume_tick", {31'd0, tick_p}, 32'd1);
        cyc();
        chk("pre_resume2", {28'd0, cq_p}, 32'd4);
        cyc();
        load = 1'b1; ld_val = 4'd5;
        cyc();
        chk("pre_ld_cq", {28'd0, cq_p}, 32'd5);
        load = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk("pre_ld_step", {28'd0, cq_p}, (k == 3) ? 32'd6 : 32'd5);
        end

        // full-range modulus 16
        load = 1'b1; ld_val = 4'd15;
        cyc();
        chk("full_ld15", {28'd0, cq_f}, 32'd15);
        chk("clamp15_a", {28'd0, cq_a}, 32'd9);
        load = 1'b0; en = 1'b1; dir = 1'b1;
        cyc();
        chk("full_up_cq", {28'd0, cq_f}, 32'd0);
        chk("full_up_tc", {31'd0, tc_f}, 32'd1);
        dir = 1'b0;
        cyc();
        chk("full_dn_cq", {28'd0, cq_f}, 32'd15);
        chk("full_dn_tc", {31'd0, tc_f}, 32'd1);
        cyc();
        chk("full_dn2_cq", {28'd0, cq_f}, 32'd14);
        chk("full_dn2_tc", {31'd0, tc_f}, 32'd0);
        chk("full_ovf", {31'd0, ovf_f}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/acounter_updown_param.md
Name: acounter_updown_param

Overview:
- Parametrised successor to the 4-bit asynchronous-reset up counter.
- Counts up or down modulo MODULUS, with:
  - a clock-enable prescaler,
  - synchronous parallel load with clamping,
  - wrap or saturate mode,
  - a registered terminal-count pulse,
  - a sticky overflow flag.
- Used as the general event/tick counter in timing and sequencing blocks.

Parameters:
- WIDTH, 4: counter width in bits.
- MODULUS, 16: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2**WIDTH; elaboration error otherwise.
- SATURATE, 0: 0 = wrap at the boundary, 1 = hold at the boundary.
- PRESCALE, 1: the counter steps once per PRESCALE enabled cycles. Must be ≥ 1; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  count enable; advances the prescaler.
- dir  in  1  direction: 1 = up, 0 = down. Sampled on the step cycle.
- load  in  1  synchronous load strobe.
- ld_val  in  WIDTH  load value.
- clr_ovf  in  1  synchronous clear of ovf.
- cq  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered).
- ovf  out  1  sticky boundary-event flag (registered).
- tick  out  1  combinational step qualifier.

Behaviour:
- **Reset.** reset=0 forces cq=0, tc=0, ovf=0 and prescaler pcnt=0 immediately, without waiting for a clock edge. Reset asserted mid-count has the same effect. The first step can occur on the first rising edge after reset returns to 1.
- **Prescaler.** pcnt counts 0..PRESCALE-1 on each cycle with en=1 and load=0, and wraps to 0.
  - tick = en & ~load & (pcnt == PRESCALE-1).
  - With PRESCALE=1, tick = en & ~load.
  - en=0 freezes pcnt. It does not clear it.
- **Priority per edge.** load > tick > hold.
- **Load.** cq <= ld_val if ld_val < MODULUS, otherwise cq <= MODULUS-1 (clamp). Load also sets pcnt to 0 and tc to 0, and leaves ovf unchanged.
- **Up step (tick, dir=1).**
  - cq < MODULUS-1: cq+1.
  - cq == MODULUS-1: boundary event. cq becomes 0 when SATURATE=0 and holds at MODULUS-1 when SATURATE=1.
- **Down step (tick, dir=0).**
  - cq > 0: cq-1.
  - cq == 0: boundary event. cq becomes MODULUS-1 when SATURATE=0 and holds at 0 when SATURATE=1.
- **tc.** tc=1 for exactly the one cycle following an edge that performed a boundary event; tc=0 otherwise. In saturate mode, every tick at the boundary is a boundary event, so a held boundary gives tc=1 on each such tick.
- **ovf.** Set on any boundary event and held until cleared.
  - clr_ovf=1 clears it on the next edge.
  - If a boundary event and clr_ovf fall on the same edge, set wins and ovf=1.
- **Arithmetic.** All next-state arithmetic is WIDTH bits wide. cq never leaves 0..MODULUS-1, including when MODULUS=2**WIDTH.
- **Latency.** cq, tc and ovf reflect a step or load on the edge where it is sampled (one-cycle registered latency). tick is same-cycle combinational.

Test Plan:
1. Reset mid-count (MODULUS=10, PRESCALE=1, SATURATE=0):
   - Stimulus: with cq=7 and ovf=1, drive reset=0 between clock edges.
   - Required: cq=0, tc=0, ovf=0 immediately, with no clock edge.
2. Up wrap (same instance):
   - Stimulus: release reset, en=1, dir=1 for 12 cycles.
   - Required: cq follows 0,1,…,9,0,1; tc=1 only in the cycle cq returns to 0; ovf=1 from then on.
3. Down wrap and load clamp (same instance):
   - Stimulus: load=1, ld_val=13.
   - Required: cq=9.
   - Stimulus: load 0, then en=1, dir=0.
   - Required: cq goes 0→9 with a one-cycle tc pulse.
   - Stimulus: load=1 and en=1 in the same cycle.
   - Required: load wins.
4. Saturate (SATURATE=1, MODULUS=10):
   - Stimulus: load 8, then up for 4 ticks.
   - Required: cq goes 9,9,9,9; tc=1 after each of the last three ticks; ovf=1.
   - Stimulus: assert clr_ovf together with a boundary tick.
   - Required: ovf stays 1.
   - Stimulus: assert clr_ovf alone.
   - Required: ovf=0.
5. Prescale (PRESCALE=3, MODULUS=16):
   - Stimulus: en=1 continuously.
   - Required: cq increments every 3rd edge; tick is high on every 3rd cycle.
   - Stimulus: drop en for 2 cycles when pcnt=1.
   - Required: the next step is delayed by exactly 2 cycles.
   - Stimulus: load.
   - Required: pcnt resets, and the next step follows 3 enabled cycles later.
6. Full-range width (WIDTH=4, MODULUS=16):
   - Stimulus: count up from 15.
   - Required: cq=0, tc=1.
   - Stimulus: count down from 0.
   - Required: cq=15, with no X and no out-of-range values.
